dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_SIZE, default 7, SHALL set the word-address width of the shared data memory.
REQ-002 Parameter BYTE_SIZE, default 32, SHALL set the data word width.
REQ-003 Parameter MAX_LOCK, default 15, SHALL set the maximum consecutive grants a locking requester may hold.
REQ-004 The port list SHALL be, with clock and reset first:
- clock  in  1  sole clock; rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid[i], i=0..1  in  1  requester i has a request pending; 0 = CPU, 1 = loader/debug.
- req_ready[i]  out  1  request accepted this cycle when valid and ready are both high.
- req_wen[i]  in  1  request is a write (1) or a read (0).
- req_addr[i]  in  ADDR_SIZE  word address.
- req_wdata[i]  in  BYTE_SIZE  write data.
- req_lock[i]  in  1  requester asks to keep the grant.
- rsp_valid[i]  out  1  one-cycle pulse carrying read data.
- rsp_rdata[i]  out  BYTE_SIZE  read data; valid only while rsp_valid[i] is high.
- mem_wen  out  1  memory write enable.
- mem_addr  out  ADDR_SIZE  shared read and write address.
- mem_wdata  out  BYTE_SIZE  memory write data.
- mem_rdata  in  BYTE_SIZE  combinational read data from the memory.

Function
REQ-005 Arbitration SHALL be combinational over req_valid, the round-robin pointer rr_ptr and the FSM state; req_ready SHALL be high for at most one requester per cycle.
REQ-006 In state OPEN, with both requesters valid, the requester equal to rr_ptr SHALL be granted; with one requester valid, that requester SHALL be granted.
REQ-007 After each accepted request in OPEN, rr_ptr SHALL move to the other requester.
REQ-008 An accepted request SHALL be registered into stage M: address, wen, wdata and owner id.
REQ-009 In the cycle after acceptance, stage M SHALL drive mem_addr and mem_wdata, and SHALL drive mem_wen equal to the registered wen.
REQ-010 When stage M is empty, mem_wen SHALL be 0.
REQ-011 For a read, mem_rdata SHALL be captured at the end of the stage-M cycle; rsp_valid[owner] SHALL pulse for exactly one cycle two cycles after acceptance, with rsp_rdata[owner] equal to the captured data.
REQ-012 A write SHALL produce no rsp_valid.
REQ-013 Throughput SHALL be one access per cycle; responses have no backpressure.
REQ-014 A read accepted in the cycle after a write to the same address SHALL return the newly written data.
REQ-015 The FSM SHALL have two states, OPEN and LOCKED.
REQ-016 OPEN -> LOCKED: on acceptance of a request from i with req_lock[i]=1; lock_owner<=i and lock_cnt<=1.
REQ-017 In LOCKED, only lock_owner SHALL be eligible for grant; each acceptance SHALL increment lock_cnt.
REQ-018 LOCKED -> OPEN SHALL occur when any of the following holds:
- req_lock[owner]=0 at acceptance;
- req_valid[owner]=0 in any LOCKED cycle;
- lock_cnt reaches MAX_LOCK at acceptance.
REQ-019 On any LOCKED -> OPEN transition, rr_ptr SHALL be set to the non-owner.
REQ-020 A locking requester SHALL be forced to release after MAX_LOCK grants even if req_lock stays high, so the other requester cannot starve.
REQ-021 Address and data widths SHALL pass unmodified; there is no address arithmetic, and the lock_cnt width SHALL be $clog2(MAX_LOCK+1).

Reset
REQ-022 Assertion of reset_n low SHALL asynchronously clear every register: state=OPEN, rr_ptr=0, lock_owner=0, lock_cnt=0, stage M empty, response registers empty.
REQ-023 While reset_n is low, and in the first cycle after deassertion, the outputs SHALL be req_ready=0 for both requesters, rsp_valid=0 for both, mem_wen=0, mem_addr=0, mem_wdata=0 and rsp_rdata=0.
REQ-024 A reset in mid-operation SHALL discard in-flight accesses: no rsp_valid, and no mem_wen after assertion.

Structure
REQ-025 A shared package dmem_pkg SHALL hold the arb_state_t enum (OPEN, LOCKED), the requester-id typedef, and the constants NUM_REQ=2, DMEM_ADDR_SIZE=7 and DMEM_BYTE_SIZE=32.
REQ-026 Grant selection SHALL be one sub-module, rr_grant, that maps (valid vector, rr_ptr, state, lock_owner) to a one-hot grant; the rest stays in dmem_arbiter.

Verification
REQ-027 Bench scenarios:
- Write then read: CPU writes 0xDEADBEEF to address 5, then reads address 5 the next cycle -> rsp_valid[0] pulses 2 cycles after the read is accepted, with data 0xDEADBEEF.
- Both requesters valid continuously, no lock, after reset -> grants alternate 0,1,0,1 and each requester gets exactly 50% of accepts over 20 cycles.
- Loader holds lock and valid, MAX_LOCK=15 -> exactly 15 consecutive loader grants, then CPU is granted the next cycle.
- Loader drops valid while LOCKED -> state returns to OPEN the same cycle; CPU is granted on the following cycle.
- Reset_n pulsed low 1 cycle after a read is accepted -> no rsp_valid, mem_wen=0, and the first post-reset grant goes to requester 0.
- Single requester, back-to-back reads of addresses 0..7 -> 8 responses, one per cycle, in order, each arriving 2 cycles after its accept.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the two-requester data-memory arbiter.
package dmem_pkg;
    localparam int NUM_REQ        = 2;
    localparam int DMEM_ADDR_SIZE = 7;
    localparam int DMEM_BYTE_SIZE = 32;

    typedef enum logic {OPEN, LOCKED} arb_state_t;
    typedef logic [$clog2(NUM_REQ)-1:0] req_id_t;
endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester, response and memory-side bundle of the data-memory arbiter.
interface dmem_arbiter_if #(
    parameter int ADDR_SIZE = 7,
    parameter int BYTE_SIZE = 32
);
    import dmem_pkg::*;

    logic [NUM_REQ-1:0]                req_valid;
    logic [NUM_REQ-1:0]                req_ready;
    logic [NUM_REQ-1:0]                req_wen;
    logic [NUM_REQ-1:0][ADDR_SIZE-1:0] req_addr;
    logic [NUM_REQ-1:0][BYTE_SIZE-1:0] req_wdata;
    logic [NUM_REQ-1:0]                req_lock;
    logic [NUM_REQ-1:0]                rsp_valid;
    logic [NUM_REQ-1:0][BYTE_SIZE-1:0] rsp_rdata;
    logic                              mem_wen;
    logic [ADDR_SIZE-1:0]              mem_addr;
    logic [BYTE_SIZE-1:0]              mem_wdata;
    logic [BYTE_SIZE-1:0]              mem_rdata;

    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata, req_lock, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, mem_wen, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_wen, req_addr, req_wdata, req_lock, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, mem_wen, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_arbiter_rr_grant.sv
// One-hot grant: round-robin between valid requesters in OPEN, owner-only in LOCKED.
module rr_grant
    import dmem_pkg::*;
(
    input  logic [NUM_REQ-1:0] valid,
    input  req_id_t            rr_ptr,
    input  arb_state_t         state,
    input  req_id_t            lock_owner,
    output logic [NUM_REQ-1:0] grant
);
    req_id_t other;
    assign other = ~rr_ptr;

    always_comb begin
        grant = '0;
        if (state == LOCKED)
            grant[lock_owner] = valid[lock_owner];
        else if (valid[rr_ptr])
            grant[rr_ptr] = 1'b1;
        else if (valid[other])
            grant[other] = 1'b1;
    end
endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: grant, one-cycle memory stage M, registered read response.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_SIZE = DMEM_ADDR_SIZE,
    parameter int BYTE_SIZE = DMEM_BYTE_SIZE,
    parameter int MAX_LOCK  = 15
) (
    input  logic           clock,
    input  logic           reset_n,
    dmem_arbiter_if.slave  bus
);
    localparam int LCW = $clog2(MAX_LOCK + 1);
    localparam logic [LCW-1:0] CNT_ONE  = LCW'(1);
    localparam logic [LCW-1:0] CNT_LAST = LCW'(MAX_LOCK - 1);

    typedef struct packed {
        logic                 vld;
        logic                 wen;
        req_id_t              id;
        logic [ADDR_SIZE-1:0] addr;
        logic [BYTE_SIZE-1:0] wdata;
    } mstage_t;

    arb_state_t state_q, state_d;
    req_id_t    rr_ptr_q, rr_ptr_d;
    req_id_t    lock_owner_q, lock_owner_d;
    logic [LCW-1:0] lock_cnt_q, lock_cnt_d;
    mstage_t    m_q, m_d;
    logic [NUM_REQ-1:0]                rsp_vld_q, rsp_vld_d;
    logic [NUM_REQ-1:0][BYTE_SIZE-1:0] rsp_rdata_q, rsp_rdata_d;
    // Holds grants off for the first cycle after reset release.
    logic       started_q;

    logic [NUM_REQ-1:0] grant, ready, acc_vec;
    logic               accept;
    req_id_t            acc_id;

    rr_grant u_grant (
        .valid      (bus.req_valid),
        .rr_ptr     (rr_ptr_q),
        .state      (state_q),
        .lock_owner (lock_owner_q),
        .grant      (grant)
    );

    assign ready   = grant & {NUM_REQ{started_q}};
    assign acc_vec = bus.req_valid & ready;
    assign accept  = |acc_vec;
    assign acc_id  = req_id_t'(acc_vec[1]);

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        lock_owner_d = lock_owner_q;
        lock_cnt_d   = lock_cnt_q;
        m_d          = m_q;
        rsp_vld_d    = '0;
        rsp_rdata_d  = rsp_rdata_q;

        m_d.vld = accept;
        if (accept) begin
            m_d.wen   = bus.req_wen[acc_id];
            m_d.id    = acc_id;
            m_d.addr  = bus.req_addr[acc_id];
            m_d.wdata = bus.req_wdata[acc_id];
        end

        // Memory read data is combinational, so it is captured at the end of the M cycle.
        if (m_q.vld && !m_q.wen) begin
            rsp_vld_d[m_q.id]   = 1'b1;
            rsp_rdata_d[m_q.id] = bus.mem_rdata;
        end

        unique case (state_q)
            OPEN: begin
                if (accept) begin
                    rr_ptr_d = ~acc_id;
                    if (bus.req_lock[acc_id] && MAX_LOCK > 1) begin
                        state_d      = LOCKED;
                        lock_owner_d = acc_id;
                        lock_cnt_d   = CNT_ONE;
                    end
                end
            end
            LOCKED: begin
                if (!bus.req_valid[lock_owner_q] ||
                    (accept && (!bus.req_lock[lock_owner_q] || lock_cnt_q >= CNT_LAST))) begin
                    state_d    = OPEN;
                    rr_ptr_d   = ~lock_owner_q;
                    lock_cnt_d = '0;
                end else if (accept) begin
                    lock_cnt_d = lock_cnt_q + CNT_ONE;
                end
            end
            default: state_d = OPEN;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= OPEN;
            rr_ptr_q     <= '0;
            lock_owner_q <= '0;
            lock_cnt_q   <= '0;
            m_q          <= '0;
            rsp_vld_q    <= '0;
            rsp_rdata_q  <= '0;
            started_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            lock_owner_q <= lock_owner_d;
            lock_cnt_q   <= lock_cnt_d;
            m_q          <= m_d;
            rsp_vld_q    <= rsp_vld_d;
            rsp_rdata_q  <= rsp_rdata_d;
            started_q    <= 1'b1;
        end
    end

    assign bus.req_ready = ready;
    assign bus.mem_wen   = m_q.vld & m_q.wen;
    assign bus.mem_addr  = m_q.addr;
    assign bus.mem_wdata = m_q.wdata;
    assign bus.rsp_valid = rsp_vld_q;
    assign bus.rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: grant vector table, scoreboarded read responses, lock/reset sequences.
module tb_dmem_arbiter;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   rsp_cnt = 0;

    typedef struct {
        int          id;
        logic [31:0] data;
        int          due;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    typedef struct {
        logic [1:0] v;
        logic [1:0] wen;
        logic [1:0] rdy;
    } vec_t;
    vec_t tbl[9];

    logic [31:0] mem    [0:127];
    logic [31:0] shadow [0:127];

    dmem_arbiter_if #(.ADDR_SIZE(7), .BYTE_SIZE(32)) bus ();

    dmem_arbiter #(.ADDR_SIZE(7), .BYTE_SIZE(32), .MAX_LOCK(15)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    always @(posedge clock) if (bus.mem_wen) mem[bus.mem_addr] <= bus.mem_wdata;
    assign bus.mem_rdata = mem[bus.mem_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: reads push an expected response on accept; responses pop and compare.
    always @(negedge clock) begin
        if (reset_n) begin
            for (int i = 0; i < 2; i++) begin
                if (bus.rsp_valid[i]) begin
                    if (sb.size() == 0) begin
                        chk("rsp_unexpected", 32'(i), 32'hFFFF_FFFF);
                    end else begin
                        e = sb.pop_front();
                        chk("rsp_id", 32'(i), 32'(e.id));
                        chk("rsp_data", bus.rsp_rdata[i], e.data);
                        chk("rsp_time", 32'(cyc), 32'(e.due));
                        rsp_cnt++;
                    end
                end
            end
            while (sb.size() > 0 && sb[0].due < cyc) begin
                e = sb.pop_front();
                chk("rsp_missing", 32'(e.due), 32'(cyc));
            end
            for (int i = 0; i < 2; i++) begin
                if (bus.req_valid[i] && bus.req_ready[i]) begin
                    if (bus.req_wen[i]) shadow[bus.req_addr[i]] = bus.req_wdata[i];
                    else sb.push_back('{i, shadow[bus.req_addr[i]], cyc + 2});
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        bus.req_valid = '0;
        bus.req_wen   = '0;
        bus.req_lock  = '0;
    endtask

    // Asserts reset, checks cleared outputs, releases it and checks the dead first cycle.
    task automatic do_reset(input logic [1:0] v_dead);
        reset_n = 1'b0;
        sb.delete();
        idle();
        @(negedge clock);
        chk("rst_ready", 32'(bus.req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("rst_mem_wen", 32'(bus.mem_wen), 32'h0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
        chk("rst_rdata0", bus.rsp_rdata[0], 32'h0);
        chk("rst_rdata1", bus.rsp_rdata[1], 32'h0);
        step();
        reset_n = 1'b1;
        bus.req_valid = v_dead;
        @(negedge clock);
        chk("dead_cycle_ready", 32'(bus.req_ready), 32'h0);
        step();
    endtask

    int n0, n1, lgr;

    initial begin
        for (int i = 0; i < 128; i++) begin
            mem[i]    = 32'hA500_0000 + 32'(i);
            shadow[i] = 32'hA500_0000 + 32'(i);
        end
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        idle();

        tbl[0] = '{2'b11, 2'b00, 2'b01};
        tbl[1] = '{2'b11, 2'b00, 2'b10};
        tbl[2] = '{2'b10, 2'b10, 2'b10};
        tbl[3] = '{2'b10, 2'b00, 2'b10};
        tbl[4] = '{2'b11, 2'b00, 2'b01};
        tbl[5] = '{2'b01, 2'b01, 2'b01};
        tbl[6] = '{2'b00, 2'b00, 2'b00};
        tbl[7] = '{2'b11, 2'b00, 2'b10};
        tbl[8] = '{2'b01, 2'b01, 2'b01};

        step();
        do_reset(2'b11);

        for (int k = 0; k < 9; k++) begin
            bus.req_valid    = tbl[k].v;
            bus.req_wen      = tbl[k].wen;
            bus.req_addr[0]  = 7'(16 + k);
            bus.req_addr[1]  = 7'(40 + k);
            bus.req_wdata[0] = 32'hC0DE_0000 + 32'(k);
            bus.req_wdata[1] = 32'hF00D_0000 + 32'(k);
            @(negedge clock);
            chk($sformatf("tbl%0d_ready", k), 32'(bus.req_ready), 32'(tbl[k].rdy));
            step();
        end
        idle();
        repeat (4) step();

        // CPU write then read of address 5.
        bus.req_valid[0] = 1'b1; bus.req_wen[0] = 1'b1;
        bus.req_addr[0] = 7'd5; bus.req_wdata[0] = 32'hDEAD_BEEF;
        @(negedge clock); chk("wr_ready", 32'(bus.req_ready), 32'h1);
        step();
        bus.req_wen[0] = 1'b0;
        @(negedge clock);
        chk("rd_ready", 32'(bus.req_ready), 32'h1);
        chk("wr_mem_wen", 32'(bus.mem_wen), 32'h1);
        chk("wr_mem_addr", 32'(bus.mem_addr), 32'h5);
        chk("wr_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
        step();
        idle();
        @(negedge clock);
        chk("rd_mem_wen", 32'(bus.mem_wen), 32'h0);
        chk("rd_rsp_early", 32'(bus.rsp_valid), 32'h0);
        step();
        @(negedge clock);
        chk("rd_rsp_valid", 32'(bus.rsp_valid), 32'h1);
        chk("rd_rsp_data", bus.rsp_rdata[0], 32'hDEAD_BEEF);
        step();
        @(negedge clock);
        chk("rd_rsp_pulse", 32'(bus.rsp_valid), 32'h0);
        step();

        // Fair alternation with both requesters continuously valid.
        do_reset(2'b00);
        n0 = 0; n1 = 0;
        bus.req_valid = 2'b11;
        for (int k = 0; k < 20; k++) begin
            bus.req_addr[0] = 7'(k); bus.req_addr[1] = 7'(64 + k);
            @(negedge clock);
            chk($sformatf("alt%0d_ready", k), 32'(bus.req_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
            if (bus.req_ready[0]) n0++;
            if (bus.req_ready[1]) n1++;
            step();
        end
        chk("alt_cnt0", 32'(n0), 32'd10);
        chk("alt_cnt1", 32'(n1), 32'd10);
        idle();
        repeat (3) step();

        // Loader lock: forced release after 15 grants even with CPU waiting.
        do_reset(2'b00);
        lgr = 0;
        bus.req_valid[1] = 1'b1; bus.req_lock[1] = 1'b1;
        for (int k = 0; k < 16; k++) begin
            if (k == 1) bus.req_valid[0] = 1'b1;
            @(negedge clock);
            if (k < 15 && bus.req_ready == 2'b10) lgr++;
            if (k == 15) chk("lock_cpu_after", 32'(bus.req_ready), 32'h1);
            step();
        end
        chk("lock_grants", 32'(lgr), 32'd15);
        idle();
        repeat (3) step();

        // Loader drops valid while LOCKED.
        do_reset(2'b00);
        bus.req_valid[1] = 1'b1; bus.req_lock[1] = 1'b1;
        repeat (3) step();
        bus.req_valid = 2'b01;
        @(negedge clock); chk("drop_ready_same", 32'(bus.req_ready), 32'h0);
        step();
        @(negedge clock); chk("drop_ready_next", 32'(bus.req_ready), 32'h1);
        step();
        idle();
        repeat (3) step();

        // Reset one cycle after a read is accepted.
        do_reset(2'b00);
        bus.req_valid[0] = 1'b1; bus.req_addr[0] = 7'd3;
        @(negedge clock); chk("mid_rd_ready", 32'(bus.req_ready), 32'h1);
        step();
        do_reset(2'b11);
        @(negedge clock); chk("post_rst_grant", 32'(bus.req_ready), 32'h1);
        step();
        idle();
        repeat (3) step();

        // Back-to-back reads of 0..7 from a single requester.
        do_reset(2'b00);
        rsp_cnt = 0;
        bus.req_valid[0] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            bus.req_addr[0] = 7'(k);
            @(negedge clock);
            chk($sformatf("b2b%0d_ready", k), 32'(bus.req_ready), 32'h1);
            step();
        end
        idle();
        repeat (4) step();
        chk("b2b_rsp_cnt", 32'(rsp_cnt), 32'd8);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
